spi_arbiter: RTL and testbench

- Shares one SPI master transaction engine between N_REQ requesters (e.g. touch-panel ADC reader, DAC/config writer).
- Round-robin arbitration; latches the winner's 32-bit payload and 3-bit control; issues the command by toggling the master's level-sensitive newcommand.
- Detects completion from the master's CS low-then-high cycle; returns the master's 8-bit read byte with a one-cycle done pulse to the winner.

---
 rtl/spi_arbiter_pkg.sv | 23 ++
 rtl/spi_arbiter_if.sv | 32 +++
 rtl/spi_arbiter_rr_pick.sv | 30 +++
 rtl/spi_arbiter.sv | 158 +++++++++++++++
 tb/tb_spi_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM state encoding,
// the two accepted control codes and the default watchdog limit.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_t;

    localparam logic [2:0] CTRL_SEND16 = 3'b010;  // send16 + read8
    localparam logic [2:0] CTRL_SEND24 = 3'b011;  // send24

    localparam int TIMEOUT_CYCLES_DEF = 4096;

    // Only these two commands are forwarded to the SPI master.
    function automatic logic ctrl_is_valid(input logic [2:0] ctrl);
        return (ctrl == CTRL_SEND16) || (ctrl == CTRL_SEND24);
    endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals of the arbiter.
// slave  : the arbiter's view.
// master : the view of whatever drives requests and models the SPI master.
interface spi_arbiter_if #(
    parameter int N_REQ = 2
) ();
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_data;
    logic [3*N_REQ-1:0]  req_ctrl;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic [7:0]          rdata;
    logic                resp_err;
    logic                busy;
    logic [31:0]         spi_din;
    logic [2:0]          spi_control;
    logic                spi_newcommand;
    logic                spi_cs;
    logic [7:0]          spi_miso_dout;

    modport slave (
        input  req, req_data, req_ctrl, spi_cs, spi_miso_dout,
        output grant, done, rdata, resp_err, busy,
               spi_din, spi_control, spi_newcommand
    );

    modport master (
        output req, req_data, req_ctrl, spi_cs, spi_miso_dout,
        input  grant, done, rdata, resp_err, busy,
               spi_din, spi_control, spi_newcommand
    );
endinterface

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request scanning
// upward from i_ptr with wrap-around. Outputs are all-zero when no request.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic [IDX_W-1:0] o_idx
);
    logic             w_found;
    logic [IDX_W-1:0] w_j;

    // Scan from the pointer, taking the first hit only.
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = IDX_W'((int'(i_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_j]) begin
                w_found     = 1'b1;
                o_pick[w_j] = 1'b1;
                o_idx       = w_j;
            end
        end
    end
endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master transaction engine between
// N_REQ requesters. A command is started by toggling spi_newcommand and is
// complete once the master's CS has gone low and back high.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort transactions that
// stay in the wait states for TIMEOUT_CYCLES cycles.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic          clk,
    input logic          rst,   // asynchronous, active-low
    spi_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       r_state, w_next;
    logic [IDX_W-1:0] r_ptr, r_owner, w_idx;
    logic [N_REQ-1:0] r_grant, w_pick;
    logic [31:0]      r_din, w_sel_data;
    logic [2:0]       r_ctrl, w_sel_ctrl;
    logic             r_newcmd;
    logic [7:0]       r_rdata;
    logic             r_resp_err;
    logic             w_load, w_err_load, w_ok_load, w_timeout;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req  (bus.req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_idx)
    );

    // Select the candidate requester's payload and control.
    always_comb begin
        w_sel_data = '0;
        w_sel_ctrl = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_sel_data = bus.req_data[32*i +: 32];
                w_sel_ctrl = bus.req_ctrl[3*i +: 3];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) + 1 > 13) ? $clog2(TIMEOUT_CYCLES) + 1 : 13;
    logic [CNT_W-1:0] r_tmo_cnt;

    // Watchdog: cleared while issuing, counts through both wait states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_tmo_cnt <= '0;
        else if (r_state == ST_ISSUE)
            r_tmo_cnt <= '0;
        else if (r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH)
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end

    assign w_timeout = (r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH) &&
                       (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_timeout    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next state and datapath load strobes; a normal CS edge wins over timeout.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_err_load = 1'b0;
        w_ok_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_load = 1'b1;
                    if (ctrl_is_valid(w_sel_ctrl)) begin
                        w_next = ST_ISSUE;
                    end else begin
                        w_next     = ST_DONE;
                        w_err_load = 1'b1;
                    end
                end
            end
            ST_ISSUE: w_next = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                if (!bus.spi_cs) begin
                    w_next = ST_WAIT_HIGH;
                end else if (w_timeout) begin
                    w_next     = ST_DONE;
                    w_err_load = 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (bus.spi_cs) begin
                    w_next    = ST_DONE;
                    w_ok_load = 1'b1;
                end else if (w_timeout) begin
                    w_next     = ST_DONE;
                    w_err_load = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the winner, toggle the command line, capture the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant    <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_din      <= '0;
            r_ctrl     <= '0;
            r_newcmd   <= 1'b0;
            r_rdata    <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_grant <= w_pick;
                r_owner <= w_idx;
                r_din   <= w_sel_data;
                r_ctrl  <= w_sel_ctrl;
            end
            if (r_state == ST_ISSUE)
                r_newcmd <= ~r_newcmd;
            if (w_err_load) begin
                r_rdata    <= '0;
                r_resp_err <= 1'b1;
            end else if (w_ok_load) begin
                r_rdata    <= bus.spi_miso_dout;
                r_resp_err <= 1'b0;
            end
            if (r_state == ST_DONE) begin
                r_grant <= '0;
                r_ptr   <= (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
            end
        end
    end

    assign bus.grant          = r_grant;
    assign bus.done           = (r_state == ST_DONE) ? r_grant : '0;
    assign bus.rdata          = r_rdata;
    assign bus.resp_err       = r_resp_err;
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.spi_din        = r_din;
    assign bus.spi_control    = r_ctrl;
    assign bus.spi_newcommand = r_newcmd;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed testbench for spi_arbiter with two requesters and a
// hand-driven SPI master CS/MISO.
module tb_spi_arbiter;
    import spi_arb_pkg::*;

    localparam int N = 2;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    spi_arbiter_if #(.N_REQ(N)) bus ();

    spi_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [2:0] c);
        bus.req_data[32*i +: 32] = d;
        bus.req_ctrl[3*i +: 3]   = c;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // CS low for 'low' cycles, then high; returns just after the edge that
    // sees CS high, i.e. in the done cycle.
    task automatic spi_xfer(input int low, input logic [7:0] miso);
        bus.spi_cs        = 1'b0;
        bus.spi_miso_dout = miso;
        repeat (low) step();
        bus.spi_cs = 1'b1;
        step();
    endtask

    initial begin
        int done_seen;
        rst               = 1'b1;
        bus.req           = '0;
        bus.req_data      = '0;
        bus.req_ctrl      = '0;
        bus.spi_cs        = 1'b1;
        bus.spi_miso_dout = '0;
        #2 rst = 1'b0;
        #10;
        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_newcmd", bus.spi_newcommand, 0);
        chk("rst_din", bus.spi_din, 0);
        chk("rst_rdata", bus.rdata, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: single send16+read8 transaction
        set_req(0, 32'h00A1B2C3, CTRL_SEND16);
        set_req(1, 32'h0BADF00D, CTRL_SEND24);
        bus.req = 2'b01;
        step();
        chk("t1_din", bus.spi_din, 32'h00A1B2C3);
        chk("t1_ctrl", bus.spi_control, 3'b010);
        chk("t1_grant", bus.grant, 2'b01);
        chk("t1_busy", bus.busy, 1);
        chk("t1_newcmd_c1", bus.spi_newcommand, 0);
        set_req(0, 32'hFFFFFFFF, 3'b111);   // must be ignored after grant
        step();
        chk("t1_newcmd_c2", bus.spi_newcommand, 1);
        spi_xfer(40, 8'h5A);
        chk("t1_done", bus.done, 2'b01);
        chk("t1_rdata", bus.rdata, 8'h5A);
        chk("t1_err", bus.resp_err, 0);
        chk("t1_din_held", bus.spi_din, 32'h00A1B2C3);
        bus.req = 2'b00;
        step();
        chk("t1_done_1cyc", bus.done, 0);
        chk("t1_grant_clr", bus.grant, 0);
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_din_idle", bus.spi_din, 32'h00A1B2C3);

        // 2: both requesters held, round-robin order 0,1,0,1
        apply_reset();
        set_req(0, 32'h11111111, CTRL_SEND24);
        set_req(1, 32'h22222222, CTRL_SEND24);
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_grant", bus.grant, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_din", bus.spi_din, (k % 2 == 0) ? 32'h11111111 : 32'h22222222);
            step();
            chk("t2_newcmd", bus.spi_newcommand, (k % 2 == 0) ? 1 : 0);
            spi_xfer(3, 8'(k + 1));
            chk("t2_done", bus.done, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_rdata", bus.rdata, k + 1);
            step();
            chk("t2_idle", bus.busy, 0);
        end
        bus.req = 2'b00;
        step();

        // 3: invalid control is rejected without a toggle
        set_req(1, 32'hCAFE0001, 3'b111);
        bus.req = 2'b10;
        step();
        chk("t3_done", bus.done, 2'b10);
        chk("t3_err", bus.resp_err, 1);
        chk("t3_rdata", bus.rdata, 0);
        chk("t3_busy", bus.busy, 1);
        chk("t3_newcmd", bus.spi_newcommand, 0);
        bus.req = 2'b00;
        step();
        chk("t3_busy_off", bus.busy, 0);
        chk("t3_done_off", bus.done, 0);

        // 4a: requester drops req during WAIT_HIGH
        set_req(0, 32'h0000BEEF, CTRL_SEND16);
        bus.req = 2'b01;
        step();
        chk("t4_grant", bus.grant, 2'b01);
        step();
        chk("t4_newcmd", bus.spi_newcommand, 1);
        bus.spi_cs        = 1'b0;
        bus.spi_miso_dout = 8'hC3;
        step();
        step();
        bus.req = 2'b00;
        step();
        bus.spi_cs = 1'b1;
        step();
        chk("t4_done", bus.done, 2'b01);
        chk("t4_rdata", bus.rdata, 8'hC3);
        chk("t4_err", bus.resp_err, 0);
        step();

        // 4b: async reset during WAIT_HIGH
        set_req(1, 32'h12345678, CTRL_SEND16);
        bus.req = 2'b10;
        step();
        chk("t4b_grant", bus.grant, 2'b10);
        step();
        bus.spi_cs = 1'b0;
        step();
        step();
        chk("t4b_busy_pre", bus.busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t4b_grant_rst", bus.grant, 0);
        chk("t4b_busy_rst", bus.busy, 0);
        chk("t4b_din_rst", bus.spi_din, 0);
        chk("t4b_rdata_rst", bus.rdata, 0);
        bus.spi_cs = 1'b1;
        done_seen  = 0;
        repeat (4) begin
            step();
            if (bus.done != 0) done_seen++;
        end
        chk("t4b_no_done", done_seen, 0);
        bus.req = 2'b00;
        @(posedge clk);
        #1 rst = 1'b1;

        // 5: CS never falls after issue
        apply_reset();
        set_req(0, 32'h00000005, CTRL_SEND16);
        bus.req = 2'b01;
        step();
        step();
        chk("t5_newcmd", bus.spi_newcommand, 1);
        done_seen = 0;
`ifdef SPI_ARB_TIMEOUT_EN
        repeat (15) begin
            step();
            if (bus.done != 0) done_seen++;
        end
        chk("t5_no_early_done", done_seen, 0);
        step();
        chk("t5_tmo_done", bus.done, 2'b01);
        chk("t5_tmo_err", bus.resp_err, 1);
        chk("t5_tmo_rdata", bus.rdata, 0);
        bus.req = 2'b00;
        step();
        chk("t5_newcmd_kept", bus.spi_newcommand, 1);
`else
        repeat (200) begin
            step();
            if (bus.done != 0) done_seen++;
        end
        chk("t5_never_done", done_seen, 0);
        chk("t5_still_busy", bus.busy, 1);
        chk("t5_newcmd_kept", bus.spi_newcommand, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
